cp0_ex: RTL

Coprocessor-0 exception responder for the MIPS pipeline. It accepts the exception, interrupt and `eret` requests presented by the MEM stage, commits the architectural exception state (Status, Cause, EPC, BadVAddr, Count/Compare), and drives `MEM_ex`, `MEM_eret_flush` and `EPC`. Those three signals are the redirect and flush inputs consumed by the next-PC and flush logic. It also serves `mtc0`/`mfc0` accesses from the MEM stage.

---
 rtl/cp0_ex.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cp0_ex.sv
// CP0 exception responder: commits exception/interrupt/eret state from the MEM stage,
// serves mtc0/mfc0, and runs the Count/Compare timer.
module cp0_ex #(
  parameter logic [4:0] EX_INT  = 5'h00,
  parameter logic [4:0] EX_ADEL = 5'h04,
  parameter logic [4:0] EX_ADES = 5'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  input  logic        MEM_ex_in,
  input  logic [4:0]  MEM_ExcCode,
  input  logic        MEM_bd,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_badvaddr,
  input  logic        MEM_eret,
  input  logic        MEM_mtc0,
  input  logic [4:0]  MEM_cp0_addr,
  input  logic [31:0] MEM_cp0_wdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_rdata,
  output logic        MEM_ex,
  output logic        MEM_eret_flush,
  output logic [31:0] EPC,
  output logic        int_pending
);

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic [XLEN-1:0] badvaddr_q;
  logic [XLEN-1:0] count_q;
  logic [XLEN-1:0] compare_q;
  logic [XLEN-1:0] epc_q;
  logic [7:0]      status_im_q;
  logic            status_exl_q;
  logic            status_ie_q;
  logic            cause_bd_q;
  logic            cause_ti_q;
  logic [1:0]      cause_ip_sw_q;
  logic [4:0]      cause_exccode_q;
  logic [5:0]      hw_int_q;
  logic            tick_q;

  logic [7:0]      cause_ip;
  logic            take_int;
  logic            mtc0_we;
  logic [4:0]      ex_code;
  logic [XLEN-1:0] count_next;
  logic            ti_next;

  // Hardware lines are sampled once per cycle; the timer interrupt shares IP7.
  assign cause_ip       = {hw_int_q[5] | cause_ti_q, hw_int_q[4:0], cause_ip_sw_q};
  assign int_pending    = status_ie_q & ~status_exl_q & (|(status_im_q & cause_ip));
  assign take_int       = int_pending & MEM_valid;
  assign MEM_ex         = ~rst & MEM_valid & (MEM_ex_in | take_int);
  assign MEM_eret_flush = ~rst & MEM_valid & MEM_eret & ~MEM_ex;
  assign mtc0_we        = MEM_valid & MEM_mtc0 & ~MEM_ex;
  assign ex_code        = take_int ? EX_INT : MEM_ExcCode;
  assign EPC            = epc_q;

  // Timer: software writes beat the increment; a Compare write beats a match.
  always_comb begin
    count_next = count_q;
    ti_next    = cause_ti_q;
    if (mtc0_we && MEM_cp0_addr == ADDR_COUNT) begin
      count_next = MEM_cp0_wdata;
    end else if (tick_q) begin
      count_next = count_q + XLEN'(1);
    end
    if (mtc0_we && MEM_cp0_addr == ADDR_COMPARE) begin
      ti_next = 1'b0;
    end else if (count_next == compare_q) begin
      ti_next = 1'b1;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (MEM_cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr_q;
      ADDR_COUNT:    cp0_rdata = count_q;
      ADDR_COMPARE:  cp0_rdata = compare_q;
      ADDR_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, status_im_q, 6'b0, status_exl_q, status_ie_q};
      ADDR_CAUSE:    cp0_rdata = {cause_bd_q, cause_ti_q, 14'b0, cause_ip, 1'b0, cause_exccode_q, 2'b0};
      ADDR_EPC:      cp0_rdata = epc_q;
      default:       cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q      <= '0;
      count_q         <= '0;
      compare_q       <= '0;
      epc_q           <= '0;
      status_im_q     <= '0;
      status_exl_q    <= 1'b0;
      status_ie_q     <= 1'b0;
      cause_bd_q      <= 1'b0;
      cause_ti_q      <= 1'b0;
      cause_ip_sw_q   <= '0;
      cause_exccode_q <= '0;
      hw_int_q        <= '0;
      tick_q          <= 1'b0;
    end else begin
      tick_q     <= ~tick_q;
      hw_int_q   <= hw_int;
      count_q    <= count_next;
      cause_ti_q <= ti_next;
      if (mtc0_we) begin
        case (MEM_cp0_addr)
          ADDR_COMPARE: compare_q <= MEM_cp0_wdata;
          ADDR_STATUS: begin
            status_im_q  <= MEM_cp0_wdata[15:8];
            status_exl_q <= MEM_cp0_wdata[1];
            status_ie_q  <= MEM_cp0_wdata[0];
          end
          ADDR_CAUSE:   cause_ip_sw_q <= MEM_cp0_wdata[9:8];
          ADDR_EPC:     epc_q <= MEM_cp0_wdata;
          default: ;
        endcase
      end
      // A nested exception (EXL already set) keeps the original EPC and BD.
      if (MEM_ex) begin
        if (!status_exl_q) begin
          epc_q      <= MEM_bd ? MEM_PC - XLEN'(4) : MEM_PC;
          cause_bd_q <= MEM_bd;
        end
        status_exl_q    <= 1'b1;
        cause_exccode_q <= ex_code;
        if (ex_code == EX_ADEL || ex_code == EX_ADES) begin
          badvaddr_q <= MEM_badvaddr;
        end
      end
      if (MEM_eret_flush) begin
        status_exl_q <= 1'b0;
      end
    end
  end

endmodule
